// File: rtl/apb_slave_regfile.sv
// APB completer backing a word-addressed 32-bit register file in a fixed address window,
// with parameterised wait states and decode/permission error signalling.

module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CA00,
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [5:0]  r_idx;
  logic        r_write;
  logic        r_err;
  logic        r_pready;
  logic [31:0] r_prdata;
  logic        r_pslverr;
  logic [31:0] r_regs [64];

  logic [5:0]  w_idx;
  logic        w_err;
  logic [31:0] w_rd_setup;
  logic [31:0] w_rd_held;
  logic        w_commit;
  logic        w_unused_addr_lsbs;

  // Window miss, index past the implemented words, or a write to the read-only ID word.
  function automatic logic decode_err(input logic [31:0] addr, input logic wr);
    logic [5:0] idx;
    idx = addr[7:2];
    return (addr[31:8] != BASE_ADDR[31:8]) ||
           ({1'b0, idx} >= 7'(NUM_REGS)) ||
           (wr && (idx == 6'd0));
  endfunction

  assign w_idx              = paddr_i[7:2];
  assign w_err              = decode_err(paddr_i, pwrite_i);
  assign w_unused_addr_lsbs = &{1'b0, paddr_i[1:0]};

  // Read data for a zero-wait transfer comes straight from the setup-phase decode;
  // otherwise from the address captured at setup.
  assign w_rd_setup = (pwrite_i || w_err) ? 32'd0 :
                      (w_idx == 6'd0)     ? ID_VALUE : r_regs[w_idx];
  assign w_rd_held  = (r_write || r_err)  ? 32'd0 :
                      (r_idx == 6'd0)     ? ID_VALUE : r_regs[r_idx];

  // A write commits only when the completing cycle is not abandoned.
  assign w_commit = (r_state == S_READY) && psel_i && r_write && !r_err;

  // Transfer FSM with registered APB response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= 6'd0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_prdata  <= 32'd0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pready  <= 1'b0;
          r_prdata  <= 32'd0;
          r_pslverr <= 1'b0;
          if (psel_i && !penable_i) begin
            r_idx   <= w_idx;
            r_write <= pwrite_i;
            r_err   <= w_err;
            if (WAIT_CYCLES == 0) begin
              r_state   <= S_READY;
              r_cnt     <= 4'd0;
              r_pready  <= 1'b1;
              r_prdata  <= w_rd_setup;
              r_pslverr <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!psel_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (penable_i && (r_cnt == 4'd1)) begin
            r_state   <= S_READY;
            r_cnt     <= 4'd0;
            r_pready  <= 1'b1;
            r_prdata  <= w_rd_held;
            r_pslverr <= r_err;
          end else if (penable_i && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_READY: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_prdata  <= 32'd0;
          r_pslverr <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= 4'd0;
          r_pready  <= 1'b0;
          r_prdata  <= 32'd0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  // Register file storage; pwdata is sampled on the completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_commit) begin
      r_regs[r_idx] <= pwdata_i;
    end
  end

  assign pready_o  = r_pready;
  assign prdata_o  = r_prdata;
  assign pslverr_o = r_pslverr;

  apb_slave_regfile_checker u_checker (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_pready  (r_pready),
    .i_prdata  (r_prdata),
    .i_pslverr (r_pslverr)
  );

endmodule

// Protocol invariants of the completer response outputs.
module apb_slave_regfile_checker (
  input logic        i_clk,
  input logic        i_reset,
  input logic        i_pready,
  input logic [31:0] i_prdata,
  input logic        i_pslverr
);

  a_pready_single : assert property (@(posedge i_clk) disable iff (i_reset)
    i_pready |=> !i_pready)
    else $error("pready held high for more than one cycle");

  a_quiet_when_idle : assert property (@(posedge i_clk) disable iff (i_reset)
    !i_pready |-> ((i_prdata == 32'd0) && !i_pslverr))
    else $error("response outputs nonzero outside the completing cycle");

  a_err_no_data : assert property (@(posedge i_clk) disable iff (i_reset)
    (i_pready && i_pslverr) |-> (i_prdata == 32'd0))
    else $error("error response carried read data");

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: five completer configurations on a shared APB bus, directed and random
// transfers predicted by an array-based reference model, checked by an independent monitor.

module tb_apb_slave_regfile;

  localparam int          NI       = 5;
  localparam int          WC [NI]  = '{1, 0, 3, 15, 1};
  localparam int          NR [NI]  = '{64, 64, 64, 64, 8};
  localparam logic [31:0] BASE     = 32'hDEAD_CA00;
  localparam logic [31:0] ID       = 32'hA9B0_0001;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [NI-1:0] psel_v;
  logic          penable;
  logic [31:0]   paddr;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [NI-1:0] pready_v;
  logic [NI-1:0] pslverr_v;
  logic [31:0]   prdata_a [NI];

  int          errors;
  int          checks;
  int          cyc;
  int          pulses     [NI];
  int          exp_pulses [NI];
  logic [31:0] mdl [NI][64];
  exp_t        sb_q [$];
  exp_t        mon_e;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_slave_regfile #(
      .NUM_REGS    (NR[g]),
      .WAIT_CYCLES (WC[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .psel_i    (psel_v[g]),
      .penable_i (penable),
      .paddr_i   (paddr),
      .pwrite_i  (pwrite),
      .pwdata_i  (pwdata),
      .pready_o  (pready_v[g]),
      .prdata_o  (prdata_a[g]),
      .pslverr_o (pslverr_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void predict(input int k, input logic [31:0] addr, input logic wr,
                                  output logic err, output int idx);
    logic hit;
    hit = (addr / 32'd256) == (BASE / 32'd256);
    idx = int'((addr % 32'd256) / 32'd4);
    err = !hit || (idx >= NR[k]) || (wr && idx == 0);
  endfunction

  // Full transfer on instance k; called and returns at posedge+1.
  task automatic xfer(input int k, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    logic err;
    int   idx;
    exp_t e;
    bit   done;
    predict(k, addr, wr, err, idx);
    e.inst  = k;
    e.err   = err;
    e.rdata = (!wr && !err) ? ((idx == 0) ? ID : mdl[k][idx]) : 32'd0;
    e.cyc   = cyc + 1 + WC[k];
    sb_q.push_back(e);
    exp_pulses[k]++;
    if (wr && !err) mdl[k][idx] = wd;
    paddr = addr; pwrite = wr; pwdata = wd;
    psel_v = '0; psel_v[k] = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pready_v[k]) done = 1'b1;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL timeout inst %0d: pready never rose", k);
      sb_q.delete();
    end
    @(posedge clk); #1;
    psel_v = '0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 64; i++) mdl[k][i] = 32'd0;
  endtask

  // Monitor: pop an expectation for every pready pulse; otherwise outputs must be quiet.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NI; k++) begin
        if (pready_v[k]) begin
          pulses[k]++;
          if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_pready inst %0d: actual=1 expected=0 (cycle %0d)", k, cyc);
          end else begin
            mon_e = sb_q.pop_front();
            chk("pready_inst", k, mon_e.inst);
            chk("prdata", prdata_a[k], mon_e.rdata);
            chk("pslverr", {31'd0, pslverr_v[k]}, {31'd0, mon_e.err});
            chk("pready_cycle", cyc, mon_e.cyc);
          end
        end else begin
          chk("idle_prdata", prdata_a[k], 32'd0);
          chk("idle_pslverr", {31'd0, pslverr_v[k]}, 32'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    int          t0;
    int          p_before;
    errors = 0; checks = 0; cyc = 0;
    for (int k = 0; k < NI; k++) begin pulses[k] = 0; exp_pulses[k] = 0; end
    clear_model();
    reset = 1'b1; psel_v = '0; penable = 1'b0; paddr = 32'd0; pwrite = 1'b0; pwdata = 32'd0;
    #12;
    for (int k = 0; k < NI; k++) begin
      chk("reset_pready", {31'd0, pready_v[k]}, 32'd0);
      chk("reset_prdata", prdata_a[k], 32'd0);
      chk("reset_pslverr", {31'd0, pslverr_v[k]}, 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // ID read with one wait state, then error cases.
    xfer(0, 32'hDEAD_CA00, 1'b0, 32'd0);
    xfer(0, 32'hDEAD_CA00, 1'b1, 32'h0000_0005);
    xfer(0, 32'hDEAD_CA00, 1'b0, 32'd0);
    xfer(0, 32'hBEEF_0000, 1'b0, 32'd0);
    xfer(4, 32'hDEAD_CA20, 1'b0, 32'd0);
    xfer(4, 32'hDEAD_CA1C, 1'b1, 32'h7777_1111);
    xfer(4, 32'hDEAD_CA1C, 1'b0, 32'd0);
    xfer(4, 32'hDEAD_CA20, 1'b1, 32'h2222_3333);
    idle(1);

    // Master-style read/increment loop with zero wait states, back to back.
    t0 = cyc;
    xfer(1, 32'hDEAD_CAFE, 1'b0, 32'd0);
    xfer(1, 32'hDEAD_CAFE, 1'b1, mdl[1][63] + 32'd1);
    xfer(1, 32'hDEAD_CAFE, 1'b0, 32'd0);
    xfer(1, 32'hDEAD_CAFE, 1'b1, mdl[1][63] + 32'd1);
    chk("b2b_cycles", cyc - t0, 32'd8);
    xfer(1, 32'hDEAD_CAFC, 1'b0, 32'd0);

    // Abort a write mid-wait: no pulse, nothing committed.
    p_before = pulses[2];
    paddr = 32'hDEAD_CA08; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
    psel_v = '0; psel_v[2] = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel_v = '0; penable = 1'b0;
    idle(6);
    chk("abort_no_pulse", pulses[2], p_before);
    xfer(2, 32'hDEAD_CA08, 1'b0, 32'd0);

    // Longest wait: write then read.
    xfer(3, 32'hDEAD_CA10, 1'b1, 32'h8000_0001);
    xfer(3, 32'hDEAD_CA10, 1'b0, 32'd0);

    // Asynchronous reset in READY of an errored write.
    paddr = 32'hDEAD_CA00; pwrite = 1'b1; pwdata = 32'h1;
    psel_v = '0; psel_v[0] = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    chk("ready_before_reset", {31'd0, pready_v[0]}, 32'd1);
    chk("err_before_reset", {31'd0, pslverr_v[0]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_pready", {31'd0, pready_v[0]}, 32'd0);
    chk("async_reset_pslverr", {31'd0, pslverr_v[0]}, 32'd0);
    psel_v = '0; penable = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    clear_model();

    // Asynchronous reset mid-WAIT of a write; an earlier committed word is cleared too.
    xfer(0, 32'hDEAD_CA0C, 1'b1, 32'hCAFE_F00D);
    xfer(0, 32'hDEAD_CA0C, 1'b0, 32'd0);
    paddr = 32'hDEAD_CA04; pwrite = 1'b1; pwdata = 32'h1234_5678;
    psel_v = '0; psel_v[0] = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("wait_reset_pready", {31'd0, pready_v[0]}, 32'd0);
    chk("wait_reset_prdata", prdata_a[0], 32'd0);
    chk("wait_reset_pslverr", {31'd0, pslverr_v[0]}, 32'd0);
    psel_v = '0; penable = 1'b0;
    clear_model();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    xfer(0, 32'hDEAD_CA04, 1'b0, 32'd0);
    xfer(0, 32'hDEAD_CA0C, 1'b0, 32'd0);

    // Randomized traffic on every configuration.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 25; n++) begin
        case ($urandom_range(0, 9))
          7: begin
            a = $urandom;
            if ((a / 32'd256) == (BASE / 32'd256)) a = a ^ 32'h8000_0000;
          end
          8, 9: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
          default: a = BASE + 32'($urandom_range(0, 63) * 4);
        endcase
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        xfer(k, a, w, d);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
    end

    idle(4);
    for (int k = 0; k < NI; k++) chk("pulse_count", pulses[k], exp_pulses[k]);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
